// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port register file with a pending-write scoreboard.
//
// Purpose
//    After every reset the storage is swept to zero, one entry per clock,
//    in a CLEAR state. The block then enters RUN, where it accepts two write
//    ports and one reserve request per cycle and serves NRD combinational
//    read ports. Each entry carries a busy bit. A reserve sets the bit, and
//    a write clears it. If a reserve and a write hit the same entry in one
//    cycle, the reserve wins. Entry 0 is hard-wired to read zero and is
//    never written or reserved.
//
// Ports
//    cpu_clk          sole clock, rising edge
//    cpu_rst          synchronous active-high reset (restarts the sweep)
//    rR   [NRD*AW]    packed read addresses, lane k at [k*AW +: AW]
//    rD   [NRD*DW]    packed read data,      lane k at [k*DW +: DW]
//    rBusy[NRD]       busy bit of the entry addressed by each read lane
//    we0/wR0/wD0      write port 0 enable / address / data
//    we1/wR1/wD1      write port 1 enable / address / data (wins on collision)
//    rsv/rsv_addr     reserve request: mark entry as pending write
//    ready            high in RUN (writes and reserves accepted)
//
// Configuration
//    RF_BYPASS_EN     when defined, a RUN-state read whose address matches a
//                     same-cycle write returns that write's data (port 1 over
//                     port 0). Busy for that lane then reads 0, unless rsv
//                     targets the same address.
module regfile_mp #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic [NRD*AW-1:0] rR,
   output logic [NRD*DW-1:0] rD,
   output logic [NRD-1:0]    rBusy,
   input  logic              we0,
   input  logic [AW-1:0]     wR0,
   input  logic [DW-1:0]     wD0,
   input  logic              we1,
   input  logic [AW-1:0]     wR1,
   input  logic [DW-1:0]     wD1,
   input  logic              rsv,
   input  logic [AW-1:0]     rsv_addr,
   output logic              ready
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_cnt;
   logic              r_ready;
   logic [DEPTH-1:0]  r_busy;
   logic [DW-1:0]     r_mem [DEPTH];

   logic              w_wr0;
   logic              w_wr1;
   logic              w_rsv;
   logic [DEPTH-1:0]  w_busy_nxt;

   // Effective write/reserve strobes: only in RUN, never on a reset edge, never to entry 0.
   assign w_wr0 = we0 && (r_state == S_RUN) && !cpu_rst && (wR0 != {AW{1'b0}});
   assign w_wr1 = we1 && (r_state == S_RUN) && !cpu_rst && (wR1 != {AW{1'b0}});
   assign w_rsv = rsv && (r_state == S_RUN) && !cpu_rst && (rsv_addr != {AW{1'b0}});

   // Next busy vector: a reserve takes priority over a clearing write to the same entry.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy_nxt[i] = (w_rsv && (rsv_addr == AW'(i))) ? 1'b1 :
                         ((w_wr0 && (wR0 == AW'(i))) ||
                          (w_wr1 && (wR1 == AW'(i)))) ? 1'b0 : r_busy[i];
      end
   end

   // Control FSM: sweep counter, state, registered ready and the busy scoreboard.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= {AW{1'b0}};
         r_ready <= 1'b0;
         r_busy  <= {DEPTH{1'b0}};
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_busy <= {DEPTH{1'b0}};
               // Hold the counter at the last entry instead of wrapping.
               if (r_cnt == {AW{1'b1}}) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
                  r_ready <= 1'b0;
               end
            end
            S_RUN: begin
               r_ready <= 1'b1;
               r_busy  <= w_busy_nxt;
            end
            default: begin
               r_state <= S_CLEAR;
               r_cnt   <= {AW{1'b0}};
               r_ready <= 1'b0;
               r_busy  <= {DEPTH{1'b0}};
            end
         endcase
      end
   end

   // Storage: zeroed by the sweep in CLEAR; in RUN port 1 is written last so it wins a collision.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst && (r_state == S_CLEAR)) begin
         r_mem[r_cnt] <= {DW{1'b0}};
      end else begin
         if (w_wr0) begin
            r_mem[wR0] <= wD0;
         end
         if (w_wr1) begin
            r_mem[wR1] <= wD1;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      logic          w_bsy;

      assign w_addr = rR[k*AW +: AW];

      // Combinational read lane: zero in CLEAR and for entry 0, optional write bypass in RUN.
      always_comb begin
         w_data = {DW{1'b0}};
         w_bsy  = 1'b0;
         if ((r_state == S_RUN) && (w_addr != {AW{1'b0}})) begin
            w_data = r_mem[w_addr];
            w_bsy  = r_busy[w_addr];
`ifdef RF_BYPASS_EN
            if (w_wr1 && (wR1 == w_addr)) begin
               w_data = wD1;
               w_bsy  = w_rsv && (rsv_addr == w_addr);
            end else if (w_wr0 && (wR0 == w_addr)) begin
               w_data = wD0;
               w_bsy  = w_rsv && (rsv_addr == w_addr);
            end else begin
               w_data = r_mem[w_addr];
               w_bsy  = r_busy[w_addr];
            end
`endif
         end else begin
            w_data = {DW{1'b0}};
            w_bsy  = 1'b0;
         end
      end

      assign rD[k*DW +: DW] = w_data;
      assign rBusy[k]       = w_bsy;
   end

   assign ready = r_ready;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; depth = 2**AW entries.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 cpu_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 cpu_rst  input  1  reset; synchronous, active-high.
REQ-006 rR  input  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-007 rD  output  NRD*DW  packed read data; port k at bits [k*DW +: DW].
REQ-008 rBusy  output  NRD  per-read-port scoreboard busy flag for addressed entry.
REQ-009 we0, wR0, wD0  input  1/AW/DW  write port 0 enable, address, data.
REQ-010 we1, wR1, wD1  input  1/AW/DW  write port 1 enable, address, data.
REQ-011 rsv, rsv_addr  input  1/AW  reserve request: mark entry as pending write.
REQ-012 ready  output  1  high when the block is in RUN and accepts writes and reserves.

Function
REQ-013 The block SHALL implement a two-state FSM: CLEAR (sweeps storage) and RUN (normal operation).
REQ-014 In CLEAR, a counter SHALL advance from 0 to 2**AW-1, zeroing one entry per cycle; after the cycle that zeroes entry 2**AW-1, the state SHALL be RUN.
REQ-015 In CLEAR, ready, every rD lane, and every rBusy bit SHALL be 0; writes and reserves SHALL be ignored.
REQ-016 Reads SHALL be combinational: rD lane k equals the entry at rR lane k in the same cycle.
REQ-017 Entry 0 SHALL always read 0; writes and reserves to address 0 SHALL be discarded.
REQ-018 A write in RUN SHALL update storage on the rising edge; data is visible on reads from the next cycle (bypass per REQ-026).
REQ-019 If we0 and we1 target the same address in one cycle, port 1 data SHALL be stored.
REQ-020 A write on either port SHALL clear the busy bit of its address on the same edge.
REQ-021 rsv in RUN SHALL set the busy bit of rsv_addr on the edge; a same-cycle write to the same address SHALL NOT clear it (reserve wins).
REQ-022 rBusy lane k SHALL equal the busy bit of the entry at rR lane k.
REQ-023 Address arithmetic SHALL be unsigned and AW bits wide; the clear counter SHALL NOT wrap past 2**AW-1.

Reset
REQ-024 An edge with cpu_rst=1 SHALL enter CLEAR with counter=0, clear all busy bits at once, and force ready=0; this applies equally mid-CLEAR (sweep restarts at 0) and in RUN.
REQ-025 After cpu_rst deasserts, ready SHALL rise exactly 2**AW cycles later (32 cycles at AW=5).

Configuration
REQ-026 Macro RF_BYPASS_EN: when defined, a RUN-state read whose address matches an enabled same-cycle write (address != 0) SHALL return that write's data (port 1 over port 0), and rBusy for that lane SHALL read 0 unless rsv targets the same address; when undefined, reads return stored values only and rBusy reflects registered state only.

Verification
REQ-027 Reset then idle -> ready=0 for 32 cycles, ready=1 on the 33rd; all rD=0 throughout.
REQ-028 RUN: we0=1, wR0=5, wD0=0xDEADBEEF; same cycle rR lane0=5 -> without RF_BYPASS_EN, old value (0) that cycle and 0xDEADBEEF next; with the macro, 0xDEADBEEF in the same cycle.
REQ-029 we0 (wR0=7, wD0=0x11) and we1 (wR1=7, wD1=0x22) together -> entry 7 reads 0x22; write to address 0 with 0xFFFFFFFF -> rD reads 0.
REQ-030 rsv, rsv_addr=9 -> rBusy=1 on reads of 9 next cycle; we1 (wR1=9) -> rBusy=0 after; rsv and write to 9 in one cycle -> rBusy stays 1.
REQ-031 cpu_rst pulsed at clear cycle 10 -> sweep restarts; ready rises 32 cycles after deassert; writes issued during CLEAR leave entries at 0.
